// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: walks the power-of-two barrel stages (MSB first), one stage per clock.
// Supports logical left and arithmetic right shifts with a start/ready, result_valid handshake.
module shift_sequencer #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SHAMT_W    = 5,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic               start_i,
    input  logic               lr_shift_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic               flush_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               result_valid_o,
    output logic [WIDTH-1:0]   result_o
);

    localparam int unsigned StgW = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [SHAMT_W-1:0]  amt_q, amt_d;
    logic                dir_q, dir_d;
    logic [StgW-1:0]     stg_q, stg_d;
    logic [WIDTH-1:0]    result_q, result_d;

    logic [WIDTH-1:0]    stage_acc;
    logic                stage_bit;
    logic                low_zero;

    // Shift for the current stage, its enable bit, and whether all lower amount bits are clear.
    always_comb begin
        stage_acc = acc_q;
        stage_bit = 1'b0;
        low_zero  = 1'b1;
        for (int unsigned i = 0; i < SHAMT_W; i++) begin
            if (stg_q == StgW'(i)) begin
                stage_bit = amt_q[i];
                if (dir_q) begin
                    stage_acc = $unsigned($signed(acc_q) >>> (2 ** i));
                end else begin
                    stage_acc = acc_q << (2 ** i);
                end
            end
            if ((StgW'(i) < stg_q) && amt_q[i]) begin
                low_zero = 1'b0;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        amt_d          = amt_q;
        dir_d          = dir_q;
        stg_d          = stg_q;
        result_d       = result_q;
        ready_o        = 1'b0;
        busy_o         = 1'b0;
        result_valid_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                ready_o = 1'b1;
                if (start_i) begin
                    acc_d   = operand_i;
                    amt_d   = shamt_i;
                    dir_d   = lr_shift_i;
                    stg_d   = StgW'(SHAMT_W - 1);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                busy_o = 1'b1;
                if (flush_i) begin
                    state_d = StIdle;
                end else begin
                    if (stage_bit) begin
                        acc_d = stage_acc;
                    end
                    // A zero amount exits after the top stage, giving a one-cycle early-exit latency.
                    if ((stg_q == '0) || (EARLY_EXIT && low_zero)) begin
                        result_d = stage_bit ? stage_acc : acc_q;
                        state_d  = StDone;
                    end else begin
                        stg_d = stg_q - 1'b1;
                    end
                end
            end
            StDone: begin
                busy_o         = 1'b1;
                result_valid_o = 1'b1;
                state_d        = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            amt_q    <= '0;
            dir_q    <= 1'b0;
            stg_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            amt_q    <= amt_d;
            dir_q    <= dir_d;
            stg_q    <= stg_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: two instances (fixed latency and early exit) checked every cycle
// against a transaction-level model, plus directed cases with literal expectations.
module tb_shift_sequencer;

    localparam int W  = 32;
    localparam int SW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n   [2];
    logic          start   [2];
    logic          dir     [2];
    logic          flush   [2];
    logic [SW-1:0] shamt   [2];
    logic [W-1:0]  operand [2];
    logic          ready   [2];
    logic          busy    [2];
    logic          valid   [2];
    logic [W-1:0]  result  [2];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    shift_sequencer #(.WIDTH(W), .SHAMT_W(SW), .EARLY_EXIT(1'b0)) u_fixed (
        .clock_i(clk), .reset_n_i(rst_n[0]), .start_i(start[0]), .lr_shift_i(dir[0]),
        .shamt_i(shamt[0]), .operand_i(operand[0]), .flush_i(flush[0]), .ready_o(ready[0]),
        .busy_o(busy[0]), .result_valid_o(valid[0]), .result_o(result[0])
    );

    shift_sequencer #(.WIDTH(W), .SHAMT_W(SW), .EARLY_EXIT(1'b1)) u_early (
        .clock_i(clk), .reset_n_i(rst_n[1]), .start_i(start[1]), .lr_shift_i(dir[1]),
        .shamt_i(shamt[1]), .operand_i(operand[1]), .flush_i(flush[1]), .ready_o(ready[1]),
        .busy_o(busy[1]), .result_valid_o(valid[1]), .result_o(result[1])
    );

    // Model: phase 0 idle, 1 working with a remaining-cycle count, 2 result pulse.
    int           m_phase [2];
    int           m_rem   [2];
    logic [W-1:0] m_pend  [2];
    logic [W-1:0] m_res   [2];

    function automatic logic [W-1:0] ref_shift(bit d, int sh, logic [W-1:0] v);
        if (d) return $unsigned($signed(v) >>> sh);
        return v << sh;
    endfunction

    function automatic int ref_lat(bit ee, int sh);
        int tz;
        if (!ee) return SW;
        if (sh == 0) begin
            tz = SW - 1;
        end else begin
            tz = 0;
            while (((sh >> tz) & 1) == 0) tz++;
        end
        return SW - tz;
    endfunction

    task automatic check(string name, logic [W-1:0] got, logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k]) begin
                m_phase[k] <= 0;
                m_res[k]   <= '0;
            end else begin
                case (m_phase[k])
                    0: if (start[k]) begin
                        m_pend[k]  <= ref_shift(dir[k], int'(shamt[k]), operand[k]);
                        m_rem[k]   <= ref_lat(k == 1, int'(shamt[k]));
                        m_phase[k] <= 1;
                    end
                    1: if (flush[k]) begin
                        m_phase[k] <= 0;
                    end else if (m_rem[k] == 1) begin
                        m_res[k]   <= m_pend[k];
                        m_phase[k] <= 2;
                    end else begin
                        m_rem[k] <= m_rem[k] - 1;
                    end
                    default: m_phase[k] <= 0;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("cyc%0d ready", k), W'(ready[k]), W'(m_phase[k] == 0));
                check($sformatf("cyc%0d busy", k), W'(busy[k]), W'(m_phase[k] != 0));
                check($sformatf("cyc%0d valid", k), W'(valid[k]), W'(m_phase[k] == 2));
                check($sformatf("cyc%0d result", k), result[k], m_res[k]);
            end
        end
    end

    // Called at posedge+1 with the instance idle; returns one cycle after the result pulse.
    task automatic run_op(int k, bit d, int sh, logic [W-1:0] op, logic [W-1:0] exp_res,
                          int exp_lat, string name);
        int lat;
        lat        = 0;
        start[k]   = 1'b1;
        dir[k]     = d;
        shamt[k]   = SW'(sh);
        operand[k] = op;
        @(posedge clk); #1;
        start[k]   = 1'b0;
        operand[k] = $urandom;
        shamt[k]   = SW'($urandom_range(0, 31));
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (valid[k]) begin
                lat = i;
                break;
            end
        end
        check({name, " latency"}, W'(lat), W'(exp_lat));
        check({name, " result"}, result[k], exp_res);
        @(posedge clk); #1;
    endtask

    initial begin
        int pulses;
        int lat;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; start[k] = 1'b0; dir[k] = 1'b0; flush[k] = 1'b0;
            shamt[k] = '0; operand[k] = '0;
            m_phase[k] = 0; m_rem[k] = 0; m_pend[k] = '0; m_res[k] = '0;
        end
        @(posedge clk); #1;
        chk_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("reset ready", W'(ready[k]), 32'd1);
            check("reset busy", W'(busy[k]), 32'd0);
            check("reset valid", W'(valid[k]), 32'd0);
            check("reset result", result[k], 32'h0);
            rst_n[k] = 1'b1;
        end
        @(posedge clk); #1;

        run_op(0, 1'b0, 8, 32'h0000_00FF, 32'h0000_FF00, 5, "sll8");
        run_op(0, 1'b1, 31, 32'h8000_0000, 32'hFFFF_FFFF, 5, "sra31");
        run_op(0, 1'b1, 4, 32'h7FFF_FFFF, 32'h07FF_FFFF, 5, "sra4");
        run_op(0, 1'b0, 0, 32'h1234_5678, 32'h1234_5678, 5, "fixed sh0");
        run_op(1, 1'b0, 0, 32'h1234_5678, 32'h1234_5678, 1, "early sh0");
        run_op(1, 1'b0, 16, 32'h1234_5678, 32'h5678_0000, 1, "early sh16");
        run_op(1, 1'b0, 1, 32'h1234_5678, 32'h2468_ACF0, 5, "early sh1");
        run_op(1, 1'b0, 31, 32'h0000_0003, 32'h8000_0000, 5, "early sll31");
        run_op(1, 1'b1, 12, 32'hF000_0000, 32'hFFFF_0000, 3, "early sra12");

        // start held high across an entire operation
        start[0] = 1'b1; dir[0] = 1'b0; shamt[0] = 5'd4; operand[0] = 32'h1;
        @(posedge clk); #1;
        operand[0] = 32'h2;
        pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (valid[0]) pulses++;
            if (i <= 5) check("hold ready low", W'(ready[0]), 32'd0);
        end
        check("hold pulses", W'(pulses), 32'd1);
        check("hold first result", result[0], 32'h0000_0010);
        check("hold idle ready", W'(ready[0]), 32'd1);
        @(posedge clk); #1;
        check("hold second accepted", W'(busy[0]), 32'd1);
        start[0] = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (valid[0]) begin
                lat = i;
                break;
            end
        end
        check("hold second latency", W'(lat), 32'd5);
        check("hold second result", result[0], 32'h0000_0020);
        @(posedge clk); #1;

        // flush during the second busy cycle
        start[0] = 1'b1; shamt[0] = 5'd3; operand[0] = 32'h5;
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(posedge clk); #1;
        flush[0] = 1'b1;
        @(posedge clk); #1;
        flush[0] = 1'b0;
        check("flush ready", W'(ready[0]), 32'd1);
        check("flush result kept", result[0], 32'h0000_0020);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (valid[0]) pulses++;
        end
        check("flush no pulse", W'(pulses), 32'd0);

        // reset in the middle of an operation
        start[0] = 1'b1; shamt[0] = 5'd8; operand[0] = 32'hFF;
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(posedge clk); #1;
        rst_n[0] = 1'b0;
        @(posedge clk); #1;
        check("midreset ready", W'(ready[0]), 32'd1);
        check("midreset result", result[0], 32'h0);
        check("midreset valid", W'(valid[0]), 32'd0);
        rst_n[0] = 1'b1;
        @(posedge clk); #1;
        run_op(0, 1'b0, 8, 32'h0000_00FF, 32'h0000_FF00, 5, "sll8 after reset");

        // random traffic, checked by the per-cycle model compare
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                rst_n[k]   = ($urandom_range(0, 63) != 0);
                start[k]   = 1'($urandom_range(0, 1));
                flush[k]   = ($urandom_range(0, 9) == 0);
                dir[k]     = 1'($urandom_range(0, 1));
                shamt[k]   = SW'($urandom_range(0, 31));
                operand[k] = $urandom;
            end
        end
        @(posedge clk); #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
